// File: rtl/imem_fetch_buffer.sv
// imem_fetch_buffer: instruction fetch stage between instruction memory and the core.
// Issues sequential word fetches over a req/gnt/rvalid handshake, buffers in-order
// responses in a DEPTH-entry FIFO and presents them as a valid/ready stream tagged
// with their PC. A redirect flushes the FIFO and discards in-flight responses.
//
// Ports:
//   clk, reset_n            clock; synchronous active-high reset (1 = reset)
//   redirect, redirect_pc   fetch restart request and new PC (bits [1:0] ignored)
//   instr, instr_pc         head instruction word and its address
//   instr_valid/ready       output stream handshake
//   mem_req, mem_addr       fetch request (combinational) and word address
//   mem_gnt                 request accepted
//   mem_rvalid, mem_rdata   in-order response
//   perf_bubbles            only with IFB_PERF_CNT_EN: saturating count of cycles in
//                           FETCH where the core was ready but no instruction was valid
//
// Optional feature macro: IFB_PERF_CNT_EN
module imem_fetch_buffer #(
  parameter int unsigned     nbit     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [nbit-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [nbit-1:0] redirect_pc,
  output logic [nbit-1:0] instr,
  output logic [nbit-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            mem_req,
  output logic [nbit-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [nbit-1:0] mem_rdata
`ifdef IFB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bubbles
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [nbit-1:0] WORD_STEP = nbit'(4);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e          state_q;
  logic [nbit-1:0] fetch_pc_q, fetch_pc_d;
  logic [nbit-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_left;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [nbit-1:0] data_mem_q [DEPTH];
  logic [nbit-1:0] pc_mem_q   [DEPTH];
  logic [nbit-1:0] instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [nbit-1:0] redirect_pc_al;
  logic            gnt_c, rv_c, drop_c, push_c, pop_c;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Request is gated so that buffered + in-flight words never exceed FIFO capacity.
  assign mem_req  = (state_q == FETCH) && !redirect && ((cnt_q + outst_q) < CW'(DEPTH));
  assign mem_addr = fetch_pc_q;

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

  // Next-state for counters, FIFO pointers and the head register.
  always_comb begin
    redirect_pc_al = {redirect_pc[nbit-1:2], 2'b00};
    gnt_c          = mem_req && mem_gnt;
    rv_c           = mem_rvalid && (outst_q != '0);
    drop_c         = rv_c && (discard_q != '0);
    // A response landing in the redirect cycle belongs to the old stream.
    push_c         = rv_c && !drop_c && !redirect;
    pop_c          = instr_valid_q && instr_ready && !redirect;
    outst_d        = outst_q + CW'(gnt_c) - CW'(rv_c);
    cnt_left       = cnt_q - CW'(pop_c);

    fetch_pc_d     = fetch_pc_q;
    resp_pc_d      = resp_pc_q;
    discard_d      = discard_q;
    cnt_d          = cnt_left + CW'(push_c);
    rd_ptr_d       = rd_ptr_q + PW'(pop_c);
    wr_ptr_d       = wr_ptr_q + PW'(push_c);
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    instr_valid_d  = 1'b0;

    if (redirect) begin
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      discard_d  = outst_d;
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
    end else begin
      if (drop_c) discard_d  = discard_q - CW'(1);
      if (gnt_c)  fetch_pc_d = fetch_pc_q + WORD_STEP;
      if (push_c) resp_pc_d  = resp_pc_q + WORD_STEP;
      // Head comes straight from the response when the FIFO would otherwise be empty.
      if (cnt_d != '0) begin
        instr_valid_d = 1'b1;
        if (cnt_left == '0) begin
          instr_d    = mem_rdata;
          instr_pc_d = resp_pc_q;
        end else begin
          instr_d    = data_mem_q[rd_ptr_d];
          instr_pc_d = pc_mem_q[rd_ptr_d];
        end
      end
    end
  end

  // FSM and control registers.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outst_q       <= '0;
      discard_q     <= '0;
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   if (redirect && (outst_d != '0)) state_q <= FLUSH;
        FLUSH:   if (discard_d == '0) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
      cnt_q         <= cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      data_mem_q[wr_ptr_q] <= mem_rdata;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (reset_n)
    !(mem_rvalid && (outst_q == '0)));

`ifdef IFB_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating bubble counter.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      perf_q <= '0;
    end else if ((state_q == FETCH) && instr_ready && !instr_valid_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_bubbles = perf_q;
`endif

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// tb_imem_fetch_buffer: randomized scoreboard bench for imem_fetch_buffer.
// A memory model answers granted fetches in order with data = f(address); the
// reference model is the expected PC stream (restarted on reset/redirect) and the
// expected fetch address sequence.
module tb_imem_fetch_buffer;

  localparam int unsigned NBIT     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n, redirect, instr_ready, mem_gnt, mem_rvalid;
  logic        instr_valid, mem_req;
  logic [31:0] redirect_pc, instr, instr_pc, mem_addr, mem_rdata;
`ifdef IFB_PERF_CNT_EN
  logic [31:0] perf_bubbles;
`endif

  always #5 clk = ~clk;

  imem_fetch_buffer #(.nbit(NBIT), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
`ifdef IFB_PERF_CNT_EN
    ,
    .perf_bubbles(perf_bubbles)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc, exp_fetch, last_gnt;
  int          n_cmp = 0, n_bad = 0, cyc = 0, n_pop = 0;
  int          gnt_pct, ready_pct, lat_min, lat_max, n_gnt, wrap_seen;
  logic        s_valid, s_req;
  logic [31:0] s_instr, s_pc, s_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at posedge+1, observe the request at posedge+3.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc);
    int lat;
    reset_n     = rst;
    redirect    = redir;
    redirect_pc = rpc;
    instr_ready = ($urandom_range(99) < 32'(ready_pct));
    mem_gnt     = !rst && ($urandom_range(99) < 32'(gnt_pct));
    mem_rvalid  = 1'b0;
    mem_rdata   = $urandom;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      gen_pc    = RESET_PC;
      exp_fetch = RESET_PC;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_fn(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    if (redir) begin
      exp_q.delete();
      gen_pc = {rpc[31:2], 2'b00};
    end
    while (exp_q.size() < 12) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
    #2;
    s_valid = instr_valid;
    s_req   = mem_req;
    s_instr = instr;
    s_pc    = instr_pc;
    s_addr  = mem_addr;
    if (redir) chk("req_in_redirect", 32'(mem_req), 32'd0);
    if (!rst && mem_req && mem_gnt) begin
      chk("mem_addr", mem_addr, exp_fetch);
      chk("outstanding_bound", 32'(pend_q.size() < int'(DEPTH)), 32'd1);
      if (last_gnt == 32'hFFFF_FFFC && mem_addr == 32'h0) wrap_seen++;
      last_gnt = mem_addr;
      lat = $urandom_range(lat_max, lat_min);
      pend_q.push_back('{mem_addr, cyc + lat});
      exp_fetch += 32'd4;
      n_gnt++;
    end
    if (redir) exp_fetch = {rpc[31:2], 2'b00};
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Wait for the next grant (bounded) and check its address.
  task automatic expect_next_grant(input string name, input logic [31:0] addr);
    n_gnt = 0;
    for (int i = 0; i < 40 && n_gnt == 0; i++) step(0, 0, 32'h0);
    if (n_gnt == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    else chk(name, last_gnt, addr);
  endtask

  // Monitor: every accepted instruction must be the next PC of the reference stream.
  bit prev_flush = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (prev_flush) chk("valid_after_flush", 32'(instr_valid), 32'd0);
    if (reset_n !== 1'b1 && instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("stream_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        chk("instr_pc", instr_pc, e);
        chk("instr", instr, mem_fn(e));
      end
    end
    prev_flush = (reset_n === 1'b1) || (redirect === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, nv, r;
    bit rst, redir;
    reset_n = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    n_gnt = 0; wrap_seen = 0; last_gnt = '0;
    gen_pc = RESET_PC; exp_fetch = RESET_PC;
    @(posedge clk); #1;

    // Reset values
    step(1, 0, 32'h0);
    step(1, 0, 32'h0);
    chk("rst_instr_valid", 32'(s_valid), 32'd0);
    chk("rst_mem_req", 32'(s_req), 32'd0);
    chk("rst_mem_addr", s_addr, RESET_PC);
    chk("rst_instr", s_instr, 32'd0);
    chk("rst_instr_pc", s_pc, 32'd0);

    // Zero-wait memory: first instruction three cycles after release, then one per cycle
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      step(0, 0, 32'h0);
      if (s_valid) first = i;
    end
    chk("first_valid_latency", 32'(first), 32'd3);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 32'h0);
      nv += int'(s_valid);
    end
    chk("stream_rate", 32'(nv), 32'd20);

    // Core stalled: exactly DEPTH grants, then requests stop; resume at 0x10
    ready_pct = 0;
    step(1, 0, 32'h0);
    n_gnt = 0;
    repeat (12) step(0, 0, 32'h0);
    chk("grants_while_stalled", 32'(n_gnt), 32'(DEPTH));
    chk("req_while_full", 32'(s_req), 32'd0);
    ready_pct = 100;
    expect_next_grant("resume_addr", 32'h10);
    repeat (8) step(0, 0, 32'h0);

    // Redirect with three slow fetches in flight
    lat_min = 5; lat_max = 5;
    step(1, 0, 32'h0);
    repeat (4) step(0, 0, 32'h0);
    chk("outstanding_before_redirect", 32'(pend_q.size()), 32'd3);
    step(0, 1, 32'h203);
    first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      step(0, 0, 32'h0);
      if (s_valid) first = i;
    end
    chk("redirect_first_pc", s_pc, 32'h200);
    chk("redirect_dropped_old", 32'(first >= 5), 32'd1);

    // Unaligned redirect target
    step(0, 1, 32'h103);
    expect_next_grant("aligned_redirect_addr", 32'h100);
    repeat (10) step(0, 0, 32'h0);

    // Reset pulse with buffered and in-flight words
    lat_min = 3; lat_max = 3; ready_pct = 0;
    step(1, 0, 32'h0);
    repeat (6) step(0, 0, 32'h0);
    step(1, 0, 32'h0);
    step(0, 0, 32'h0);
    chk("pulse_instr_valid", 32'(s_valid), 32'd0);
    chk("pulse_mem_req", 32'(s_req), 32'd0);
    ready_pct = 100; lat_min = 1; lat_max = 1;
    expect_next_grant("restart_addr", RESET_PC);
    repeat (10) step(0, 0, 32'h0);

    // Address wrap at the top of the space
    step(0, 1, 32'hFFFF_FFF4);
    wrap_seen = 0;
    repeat (12) step(0, 0, 32'h0);
    chk("addr_wrap", 32'(wrap_seen), 32'd1);

    // Random memory timing, back-pressure, redirects and occasional reset
    gnt_pct = 60; ready_pct = 70; lat_min = 1; lat_max = 6;
    for (int i = 0; i < 3000; i++) begin
      r     = int'($urandom_range(999));
      rst   = (r < 3);
      redir = !rst && (r < 30);
      step(rst, redir, (r[0]) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15))));
    end
    ready_pct = 100;
    repeat (30) step(0, 0, 32'h0);
    chk("enough_instrs", 32'(n_pop > 500), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
